// File: rtl/conway_pkg.sv
// Shared definitions for the Conway engine: default grid word width and the
// per-cell input select used by the state storage.
package conway_pkg;

  localparam int unsigned DEFAULT_DATA_SIZE = 8;

  typedef enum logic [1:0] {
    MODE_HOLD     = 2'd0,
    MODE_SHIFT    = 2'd1,
    MODE_PARALLEL = 2'd2
  } cell_mode_e;

endpackage : conway_pkg

// File: rtl/memory_cell.sv
// One stored grid bit: async-reset flop with a hold / shift / parallel input mux.
module memory_cell
  import conway_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  cell_mode_e mode,
  input  logic       shift_in,
  input  logic       par_in,
  output logic       q
);

  logic d;

  // NOTE: d gets a default before the case so no path leaves it unassigned (no latch).
  always_comb begin
    d = q;
    unique case (mode)
      MODE_SHIFT:    d = shift_in;
      MODE_PARALLEL: d = par_in;
      default:       d = q;
    endcase
  end

  // NOTE: state is updated with non-blocking assignments so all cells sample
  // their neighbours' pre-edge values and shift as one register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) q <= 1'b0;
    else     q <= d;
  end

endmodule : memory_cell

// File: rtl/system_memory_v2.sv
// Grid-state storage word: serial MSB-first loader or parallel next-generation
// capture, with RUN_MODE taking priority over LOAD_MODE.
module system_memory_v2
  import conway_pkg::*;
#(
  parameter int unsigned DATA_SIZE = DEFAULT_DATA_SIZE
) (
  input  logic                 CLK,
  input  logic                 RESET,
  input  logic [DATA_SIZE-1:0] GRID_IN,
  input  logic                 SERIAL_IN,
  input  logic                 LOAD_MODE,
  input  logic                 RUN_MODE,
  output logic [DATA_SIZE-1:0] DATA_OUT
);

  cell_mode_e           mode;
  logic [DATA_SIZE-1:0] shift_src;

  always_comb begin
    mode = MODE_HOLD;
    if (RUN_MODE)       mode = MODE_PARALLEL;
    else if (LOAD_MODE) mode = MODE_SHIFT;
  end

  // Each cell shifts in its lower neighbour; bit 0 takes the serial stream.
  assign shift_src[0] = SERIAL_IN;

  generate
    if (DATA_SIZE > 1) begin : g_chain
      assign shift_src[DATA_SIZE-1:1] = DATA_OUT[DATA_SIZE-2:0];
    end

    for (genvar i = 0; i < DATA_SIZE; i++) begin : g_cell
      memory_cell u_cell (
        .clk      (CLK),
        .rst      (RESET),
        .mode     (mode),
        .shift_in (shift_src[i]),
        .par_in   (GRID_IN[i]),
        .q        (DATA_OUT[i])
      );
    end
  endgenerate

endmodule : system_memory_v2

// File: tb/tb_system_memory_v2.sv
// Directed bench for system_memory_v2 at DATA_SIZE=5 with hand-computed expectations.
module tb_system_memory_v2;

  localparam int W = 5;

  logic         CLK = 1'b0;
  logic         RESET;
  logic [W-1:0] GRID_IN;
  logic         SERIAL_IN;
  logic         LOAD_MODE;
  logic         RUN_MODE;
  logic [W-1:0] DATA_OUT;

  int checks = 0;
  int errors = 0;

  system_memory_v2 #(.DATA_SIZE(W)) dut (
    .CLK       (CLK),
    .RESET     (RESET),
    .GRID_IN   (GRID_IN),
    .SERIAL_IN (SERIAL_IN),
    .LOAD_MODE (LOAD_MODE),
    .RUN_MODE  (RUN_MODE),
    .DATA_OUT  (DATA_OUT)
  );

  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic check(input string tag, input logic [W-1:0] expected);
    checks++;
    assert (DATA_OUT === expected)
    else begin
      errors++;
      $error("FAIL %s: observed %b expected %b", tag, DATA_OUT, expected);
    end
  endtask

  initial begin
    RESET = 1'b1; GRID_IN = 5'b11001; SERIAL_IN = 1'b1; LOAD_MODE = 1'b0; RUN_MODE = 1'b0;
    #1;
    check("reset_state", 5'b00000);
    tick();
    RESET = 1'b0;

    tick();
    check("hold_after_reset", 5'b00000);

    LOAD_MODE = 1'b1; SERIAL_IN = 1'b1; GRID_IN = 5'b00110;
    tick(); check("shift_1", 5'b00001);
    SERIAL_IN = 1'b0;
    tick(); check("shift_0a", 5'b00010);
    tick(); check("shift_0b", 5'b00100);
    SERIAL_IN = 1'b1;
    tick(); check("shift_1b", 5'b01001);

    RUN_MODE = 1'b1; GRID_IN = 5'b00110;
    tick(); check("run_priority", 5'b00110);

    RUN_MODE = 1'b0; LOAD_MODE = 1'b0; GRID_IN = '0; SERIAL_IN = 1'b0;
    tick(); check("hold_1", 5'b00110);
    tick(); check("hold_2", 5'b00110);

    // Asynchronous clear between edges, then an edge while reset is held.
    #2 RESET = 1'b1;
    #1 check("async_reset", 5'b00000);
    RUN_MODE = 1'b1; GRID_IN = 5'b11111;
    tick(); check("edge_in_reset", 5'b00000);
    RESET = 1'b0; RUN_MODE = 1'b0;

    // Shift overflow with GRID_IN undriven-looking: it must not leak into state.
    LOAD_MODE = 1'b1; SERIAL_IN = 1'b1; GRID_IN = 'x;
    tick(); check("ovf_1", 5'b00001);
    tick(); check("ovf_2", 5'b00011);
    tick(); check("ovf_3", 5'b00111);
    tick(); check("ovf_4", 5'b01111);
    tick(); check("ovf_5", 5'b11111);
    tick(); check("ovf_6", 5'b11111);
    SERIAL_IN = 1'b0;
    tick(); check("msb_drop", 5'b11110);

    LOAD_MODE = 1'b0; SERIAL_IN = 1'bx;
    tick(); check("hold_x_inputs", 5'b11110);

    RUN_MODE = 1'b1; LOAD_MODE = 1'b1; GRID_IN = 5'b10101;
    tick(); check("run_load", 5'b10101);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_system_memory_v2

// File: doc/system_memory_v2.md
Name: system_memory_v2

Overview:
- Parameterised grid-state storage register for the Conway engine.
- Holds one word of DATA_SIZE cell bits. It can be loaded in two ways:
  - bit-serially from an external loader (LOAD_MODE);
  - in parallel from the next-generation grid logic (RUN_MODE).
- Otherwise it holds its value.
- DATA_OUT feeds the grid evaluation logic and display/readout.

Parameters:
DATA_SIZE, 8, number of stored cell bits (width of GRID_IN and DATA_OUT); must be >= 1

Ports:
CLK  input  1  system clock; all state updates on rising edge
RESET  input  1  asynchronous active-high reset; clears all stored bits
GRID_IN  input  DATA_SIZE  parallel next-state data, captured when RUN_MODE=1
SERIAL_IN  input  1  serial load bit, shifted into bit 0 when LOAD_MODE=1 and RUN_MODE=0
LOAD_MODE  input  1  serial shift-load enable
RUN_MODE  input  1  parallel load enable; priority over LOAD_MODE
DATA_OUT  output  DATA_SIZE  current stored word, driven directly from the register (no combinational path from inputs)

Behaviour:
- Reset:
  - RESET=1 clears the register to all zeros immediately, independent of CLK.
  - DATA_OUT=0 within the same time step.
  - Held while RESET=1; rising CLK edges are ignored while in reset.
  - Release: the first update occurs on the first rising CLK edge after RESET falls.
  - Reset mid-shift or mid-run discards contents; no partial state is retained.
- On each rising CLK edge with RESET=0, in priority order:
  - RUN_MODE=1: DATA_OUT <= GRID_IN (full parallel load). LOAD_MODE and SERIAL_IN are ignored.
  - RUN_MODE=0, LOAD_MODE=1: shift left by one. DATA_OUT <= {DATA_OUT[DATA_SIZE-2:0], SERIAL_IN}.
    - The MSB is discarded.
    - For DATA_SIZE=1 the register simply takes SERIAL_IN.
  - Both 0: hold current value. GRID_IN and SERIAL_IN are ignored.
- Latency: one clock from input sample to DATA_OUT update.
- No handshake and no busy flag. Mode inputs are level-sensitive and sampled on every edge.
- Loading order: the first serial bit loaded ends up in the highest occupied position after DATA_SIZE shifts, i.e. serial stream is MSB-first.
- No X propagation from unused inputs: a mode that does not select an input must not let it affect state.

Decomposition:
- Shared package (conway_pkg): no typedefs required.
  - Optionally a mode-encoding enum {HOLD, SHIFT, PARALLEL} used for the per-cell select.
  - DATA_SIZE default constant may live there for reuse by the grid top.
- One natural sub-module: memory_cell. It is a single-bit async-reset DFF with a 3-way input mux:
  - hold: own Q;
  - shift: neighbour Q (bit i-1, or SERIAL_IN for bit 0);
  - parallel: GRID_IN[i].
- system_memory_v2 instantiates DATA_SIZE cells via generate and decodes RUN_MODE/LOAD_MODE into the shared select.

Test Plan:
- Reset, then 1 clock with LOAD_MODE=0, RUN_MODE=0, GRID_IN=5'b11001, SERIAL_IN=1 (DATA_SIZE=5) -> DATA_OUT=5'b00000.
- LOAD_MODE=1, RUN_MODE=0, SERIAL_IN=1, GRID_IN=5'b00110, 1 clock -> DATA_OUT=5'b00001. Then SERIAL_IN=0,0,1 over 3 clocks -> DATA_OUT=5'b01001.
- Continuing, RUN_MODE=1 with LOAD_MODE=1, GRID_IN=5'b00110, 1 clock -> DATA_OUT=5'b00110 (RUN priority, serial ignored).
- Both modes 0, GRID_IN=0, SERIAL_IN=0, 2 clocks -> DATA_OUT stays 5'b00110.
- Pulse RESET high without a clock edge -> DATA_OUT=5'b00000 immediately. A CLK edge during RESET=1 with RUN_MODE=1, GRID_IN=5'b11111 -> still 0.
- Shift overflow: LOAD_MODE=1, SERIAL_IN=1 for 6 clocks from 0 -> DATA_OUT=5'b11111. Then SERIAL_IN=0 for 1 clock -> 5'b11110 (MSB dropped).
